// File: rtl/mult_pkg.sv
// Shared constants, state encoding and the shift helper for the sequential 4x4 multiplier.
package mult_pkg;

   localparam int         N_BITS    = 4;
   localparam logic [1:0] ITER_LAST = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One shift-and-add step: carry and sum become the new upper half, sum LSB enters the lower half.
   function automatic logic [2*N_BITS-1:0] shift_step(
      input logic              c,
      input logic [N_BITS-1:0] s,
      input logic [N_BITS-1:0] lo
   );
      return {c, s, lo[N_BITS-1:1]};
   endfunction

endpackage

// File: rtl/half_adder_4_bit.sv
// 4-bit adder without carry-in; the carry-out is the fifth bit of the sum.
module half_adder_4_bit
   import mult_pkg::*;
(
   input  logic [N_BITS-1:0] i_a,
   input  logic [N_BITS-1:0] i_b,
   output logic [N_BITS-1:0] o_sum,
   output logic              o_c4
);

   logic [N_BITS:0] w_total;

   assign w_total = {1'b0, i_a} + {1'b0, i_b};
   assign o_sum   = w_total[N_BITS-1:0];
   assign o_c4    = w_total[N_BITS];

endmodule

// File: rtl/seq_multiplier_4_bit.sv
// Unsigned 4x4 shift-and-add multiplier: one shared adder, four iterations, start/busy/done handshake.
module seq_multiplier_4_bit
   import mult_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [N_BITS-1:0]     i_a,
   input  logic [N_BITS-1:0]     i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [2*N_BITS-1:0]   o_product
);

   state_t                r_state;
   logic [N_BITS-1:0]     r_mcand;
   logic [N_BITS-1:0]     r_hi;
   logic [N_BITS-1:0]     r_lo;
   logic [1:0]            r_cnt;
   logic [2*N_BITS-1:0]   r_product;
   logic                  r_busy;
   logic                  r_done;

   logic [N_BITS-1:0]     w_sum;
   logic                  w_c4;
   logic                  w_c;
   logic [N_BITS-1:0]     w_s;
   logic [2*N_BITS-1:0]   w_step;

   state_t                w_state_nxt;
   logic [N_BITS-1:0]     w_mcand_nxt;
   logic [N_BITS-1:0]     w_hi_nxt;
   logic [N_BITS-1:0]     w_lo_nxt;
   logic [1:0]            w_cnt_nxt;
   logic [2*N_BITS-1:0]   w_product_nxt;

   half_adder_4_bit u_adder (
      .i_a   (r_hi),
      .i_b   (r_mcand),
      .o_sum (w_sum),
      .o_c4  (w_c4)
   );

   // Select add or pass-through for this iteration and form the shifted {hi,lo}.
   always_comb begin
      w_c = 1'b0;
      w_s = r_hi;
      if (r_lo[0]) begin
         w_c = w_c4;
         w_s = w_sum;
      end else begin
         w_c = 1'b0;
         w_s = r_hi;
      end
      w_step = shift_step(w_c, w_s, r_lo);
   end

   // Next-state and datapath update decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_mcand_nxt   = r_mcand;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_cnt_nxt     = r_cnt;
      w_product_nxt = r_product;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = CALC;
               w_mcand_nxt = i_a;
               w_lo_nxt    = i_b;
               w_hi_nxt    = {N_BITS{1'b0}};
               w_cnt_nxt   = 2'd0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            w_hi_nxt  = w_step[2*N_BITS-1:N_BITS];
            w_lo_nxt  = w_step[N_BITS-1:0];
            w_cnt_nxt = r_cnt + 2'd1;
            if (r_cnt == ITER_LAST) begin
               w_product_nxt = w_step;
               w_state_nxt   = DONE;
            end else begin
               w_state_nxt = CALC;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and handshake registers; busy/done are registered from the next state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_mcand   <= {N_BITS{1'b0}};
         r_hi      <= {N_BITS{1'b0}};
         r_lo      <= {N_BITS{1'b0}};
         r_cnt     <= 2'd0;
         r_product <= {(2*N_BITS){1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mcand   <= w_mcand_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_cnt     <= w_cnt_nxt;
         r_product <= w_product_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= (w_state_nxt == DONE);
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_product = r_product;

endmodule

// File: tb/tb_seq_multiplier_4_bit.sv
// Self-checking bench for seq_multiplier_4_bit: scoreboard of a*b results popped on every done pulse.
module tb_seq_multiplier_4_bit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int         n_tests;
   int         n_fail;
   logic [7:0] exp_q[$];
   logic [7:0] exp_p;

   seq_multiplier_4_bit dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_a       (a),
      .i_b       (b),
      .o_busy    (busy),
      .o_done    (done),
      .o_product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every done pulse must match the oldest pending expected product.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_unexpected_done: product=%h, required no done pulse", product);
         end else begin
            exp_p = exp_q.pop_front();
            if (product !== exp_p) begin
               n_fail++;
               $display("FAIL scoreboard_product: got %h, required %h", product, exp_p);
            end
         end
      end
   end

   task automatic start_op(input logic [3:0] ta, input logic [3:0] tb_v);
      @(negedge clk);
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      exp_q.push_back({4'h0, ta} * {4'h0, tb_v});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 4'h0;
      b     = 4'h0;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
      end
      rst = 1'b0;
   endtask

   task automatic test_max();
      int n;
      start_op(4'hF, 4'hF);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL max_busy_after_accept: got %b, required 1", busy);
      end
      wait_done(n);
      n_tests++;
      if (n !== 4) begin
         n_fail++;
         $display("FAIL max_latency: done after %0d cycles past accept, required 4", n);
      end
      n_tests++;
      if (product !== 8'hE1) begin
         n_fail++;
         $display("FAIL max_product: got %h, required e1", product);
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL max_idle_after_done: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_zero_one();
      logic [3:0] ta [2];
      logic [3:0] tv [2];
      logic [7:0] te [2];
      int         n;
      ta[0] = 4'h0; tv[0] = 4'hB; te[0] = 8'h00;
      ta[1] = 4'h1; tv[1] = 4'hD; te[1] = 8'h0D;
      for (int i = 0; i < 2; i++) begin
         start_op(ta[i], tv[i]);
         wait_done(n);
         n_tests++;
         if (n !== 4) begin
            n_fail++;
            $display("FAIL zero_one_latency[%0d]: %0d cycles, required 4", i, n);
         end
         n_tests++;
         if (product !== te[i]) begin
            n_fail++;
            $display("FAIL zero_one_product[%0d]: got %h, required %h", i, product, te[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      a     = 4'h3;
      b     = 4'h5;
      start = 1'b1;
      exp_q.push_back(8'h0F);
      wait_done(n);
      n_tests++;
      if (n !== 5 || product !== 8'h0F) begin
         n_fail++;
         $display("FAIL b2b_first: %0d cycles product=%h, required 5 cycles 0f", n, product);
      end
      exp_q.push_back(8'h0F);
      @(negedge clk);
      @(negedge clk);
      a = 4'h7;
      b = 4'h9;
      exp_q.push_back(8'h3F);
      wait_done(n);
      n_tests++;
      if (n !== 4 || product !== 8'h0F) begin
         n_fail++;
         $display("FAIL b2b_second: interval %0d product=%h, required 6 0f", n + 2, product);
      end
      @(negedge clk);
      wait_done(n);
      n_tests++;
      if (n !== 5 || product !== 8'h3F) begin
         n_fail++;
         $display("FAIL b2b_third: interval %0d product=%h, required 6 3f", n + 1, product);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stop: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_busy_ignore();
      start_op(4'h6, 4'h7);
      n_tests++;
      if (product !== 8'h3F) begin
         n_fail++;
         $display("FAIL ignore_product_at_accept: got %h, required 3f", product);
      end
      a     = 4'h2;
      b     = 4'h2;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 4) begin
            n_tests++;
            if (done !== 1'b1 || product !== 8'h2A) begin
               n_fail++;
               $display("FAIL ignore_result: done=%b product=%h, required 1 2a", done, product);
            end
         end
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start_in_done: busy=%b, required 0", busy);
      end
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (busy !== 1'b0 || product !== 8'h2A) begin
            n_fail++;
            $display("FAIL ignore_hold[%0d]: busy=%b product=%h, required 0 2a", k, busy, product);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      start_op(4'h9, 4'h9);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      start_op(4'h9, 4'h9);
      wait_done(n);
      n_tests++;
      if (n !== 4 || product !== 8'h51) begin
         n_fail++;
         $display("FAIL reset_rerun: %0d cycles product=%h, required 4 51", n, product);
      end
      @(negedge clk);
   endtask

   task automatic test_exhaustive();
      int         n;
      logic [7:0] e;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            start_op(4'(ia), 4'(ib));
            wait_done(n);
            e = 8'(ia * ib);
            n_tests++;
            if (product !== e) begin
               n_fail++;
               $display("FAIL exhaustive %0d*%0d: got %h, required %h", ia, ib, product, e);
            end
            @(negedge clk);
         end
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_max();
      test_zero_one();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
